mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_sram_port.sv | 86 ++++++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: decoder memory codes and the SRAM timing FSM encoding.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_LATCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } sramState_t;

    // Code 11 is reserved and behaves like MEM_NONE.
    function automatic logic isMemReq(input logic [1:0] ctrl);
        return (ctrl == MEM_LOAD) || (ctrl == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_arbiter_sram_port.sv
// Single-port async SRAM sequencer: read = 2 cycles, write = 3 cycles; done marks the last cycle.
// Accepts start only in IDLE; caller must hold off new starts while busy.
module sram_port
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_data_oe,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    sramState_t state;
    sramState_t nextState;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state <= nextState;
            // Address/data are frozen here so the requester may change its inputs mid-access.
            if (state == IDLE && start) begin
                ram_addr <= addr;
                if (is_write) begin
                    ram_wdata <= wdata;
                end
            end
        end
    end

    always_comb begin
        nextState   = state;
        done        = 1'b0;
        ram_data_oe = 1'b0;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = is_write ? WR_SETUP : RD_SETUP;
                end
            end
            RD_SETUP: begin
                ram_oe_n  = 1'b0;
                nextState = RD_LATCH;
            end
            RD_LATCH: begin
                ram_oe_n  = 1'b0;
                done      = 1'b1;
                nextState = IDLE;
            end
            WR_SETUP: begin
                ram_data_oe = 1'b1;
                nextState   = WR_PULSE;
            end
            WR_PULSE: begin
                ram_data_oe = 1'b1;
                ram_we_n    = 1'b0;
                nextState   = WR_HOLD;
            end
            WR_HOLD: begin
                ram_data_oe = 1'b1;
                done        = 1'b1;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign rdata = ram_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage ports onto one SRAM, MEM first; valid 3 cycles after accept (store 4).
// Backpressure: combinational stall freezes the pipeline until every held request has pulsed valid.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic [1:0]        mem_ctrl,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_data_oe,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    logic              memReq;
    logic              memPend;
    logic              ifPend;
    logic              start;
    logic              startWrite;
    logic [ADDR_W-1:0] startAddr;
    logic              done;
    logic [DATA_W-1:0] portRdata;
    logic              busy;
    logic              ownerMem;
    logic              ownerWrite;
    logic              ifServed;
    logic              memServed;

    // A port in its valid cycle is already complete, so it must not be re-accepted then.
    assign memReq     = isMemReq(mem_ctrl);
    assign memPend    = memReq & ~memServed & ~mem_valid;
    assign ifPend     = if_req & ~ifServed & ~if_valid;
    assign stall      = ifPend | memPend;
    assign start      = ~busy & stall;
    assign startWrite = memPend & (mem_ctrl == MEM_STORE);
    assign startAddr  = memPend ? mem_addr : if_addr;

    sram_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sram_port (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_write   (startWrite),
        .addr       (startAddr),
        .wdata      (mem_wdata),
        .done       (done),
        .rdata      (portRdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_data_oe(ram_data_oe),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            ownerMem   <= 1'b0;
            ownerWrite <= 1'b0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            ifServed   <= 1'b0;
            memServed  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_valid  <= done & ~ownerMem;
            mem_valid <= done & ownerMem;
            if (done & ~ownerMem) begin
                if_rdata <= portRdata;
            end
            if (done & ownerMem & ~ownerWrite) begin
                mem_rdata <= portRdata;
            end
            if (start) begin
                busy       <= 1'b1;
                ownerMem   <= memPend;
                ownerWrite <= startWrite;
            end else if (done) begin
                busy <= 1'b0;
            end
            // Once the pipeline advances, any still-held request is a new one.
            if (!stall) begin
                ifServed  <= 1'b0;
                memServed <= 1'b0;
            end else begin
                if (if_valid)  ifServed  <= 1'b1;
                if (mem_valid) memServed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic [1:0]  mem_ctrl;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        stall;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_data_oe;
    logic        ram_oe_n;
    logic        ram_we_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall(stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_data_oe(ram_data_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    function automatic logic [15:0] memInit(input int i);
        if (i == 32'h10) return 16'h4A08;
        if (i == 32'h01) return 16'hBEEF;
        if (i == 32'h11) return 16'h7777;
        return 16'(i * 257) ^ 16'hA5C3;
    endfunction

    // SRAM device: 256 words aliased on address bits [7:0].
    logic [15:0] sram [0:255];
    always_comb ram_rdata = ram_oe_n ? 16'h0000 : sram[ram_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = memInit(i);
        forever begin
            @(posedge clk);
            if (!ram_we_n && ram_data_oe) sram[ram_addr[7:0]] = ram_wdata;
        end
    end

    // Reference model: an access is a countdown from acceptance to its valid pulse.
    logic [15:0] refMem [0:255];
    int          remain;
    bit          ownMem, ownWr, mIfV, mMemV, mIfSrv, mMemSrv, mStallAtEdge;
    logic [15:0] accAddr, accWdata, mIfD, mMemD;

    function automatic bit pendMemF();
        return ((mem_ctrl == 2'b01) || (mem_ctrl == 2'b10)) && !mMemSrv && !mMemV;
    endfunction

    function automatic bit pendIfF();
        return (if_req === 1'b1) && !mIfSrv && !mIfV;
    endfunction

    task automatic modelEdge();
        bit pm, pi, st, nIfV, nMemV;
        pm = pendMemF();
        pi = pendIfF();
        st = pm || pi;
        mStallAtEdge = st;
        if (rst) begin
            remain = 0; ownMem = 0; ownWr = 0; accAddr = 0; accWdata = 0;
            mIfV = 0; mMemV = 0; mIfSrv = 0; mMemSrv = 0; mIfD = 0; mMemD = 0;
            return;
        end
        nIfV = 0;
        nMemV = 0;
        if (remain == 0) begin
            if (pm) begin
                ownMem = 1; ownWr = (mem_ctrl == 2'b10); accAddr = mem_addr;
                if (ownWr) accWdata = mem_wdata;
                remain = ownWr ? 3 : 2;
            end else if (pi) begin
                ownMem = 0; ownWr = 0; accAddr = if_addr; remain = 2;
            end
        end else begin
            remain--;
            if (remain == 0) begin
                if (!ownMem) begin
                    nIfV = 1; mIfD = refMem[accAddr[7:0]];
                end else begin
                    nMemV = 1;
                    if (ownWr) refMem[accAddr[7:0]] = accWdata;
                    else mMemD = refMem[accAddr[7:0]];
                end
            end
        end
        if (!st) begin
            mIfSrv = 0; mMemSrv = 0;
        end else begin
            if (mIfV) mIfSrv = 1;
            if (mMemV) mMemSrv = 1;
        end
        mIfV = nIfV;
        mMemV = nMemV;
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; if_addr = 16'h0040; mem_ctrl = 2'b10; mem_addr = 16'h0041; mem_wdata = 16'hFFFF;
        step();
        step();
        checks++;
        if ({ram_oe_n, ram_we_n, ram_data_oe, if_valid, mem_valid} !== 5'b11000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=11000", {ram_oe_n, ram_we_n, ram_data_oe, if_valid, mem_valid});
        end
        checks++;
        if ({if_rdata, mem_rdata, ram_addr, ram_wdata} !== 64'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {if_rdata, mem_rdata, ram_addr, ram_wdata});
        end
        if_req = 0; mem_ctrl = 2'b00;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 16'h0010; mem_ctrl = 2'b00;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_pre got=%b exp=1", stall); end
        step();
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({if_valid, stall, ram_oe_n} !== {(k == 3), (k != 3), (k == 3)}) begin
                failures++; $display("FAIL fetch_cyc%0d got=%b exp=%b", k, {if_valid, stall, ram_oe_n}, {(k == 3), (k != 3), (k == 3)});
            end
            if (k < 3) begin
                checks++;
                if (ram_addr !== 16'h0010) begin failures++; $display("FAIL fetch_addr got=%h exp=0010", ram_addr); end
                step();
            end
        end
        checks++;
        if (if_rdata !== 16'h4A08) begin failures++; $display("FAIL fetch_data got=%h exp=4a08", if_rdata); end
        if_req = 0;
        step();
        checks++;
        if ({if_valid, if_rdata} !== {1'b0, 16'h4A08}) begin
            failures++; $display("FAIL fetch_hold got=%b/%h exp=0/4a08", if_valid, if_rdata);
        end
    endtask

    task automatic test_store();
        int weLow, oeHigh;
        weLow = 0; oeHigh = 0;
        mem_ctrl = 2'b10; mem_addr = 16'h8000; mem_wdata = 16'h1234;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (ram_we_n === 1'b0) weLow++;
            if (ram_data_oe === 1'b1) oeHigh++;
            checks++;
            if ({mem_valid, ram_oe_n} !== {(k == 4), 1'b1}) begin
                failures++; $display("FAIL store_cyc%0d valid/oe_n got=%b exp=%b1", k, {mem_valid, ram_oe_n}, (k == 4));
            end
            if (k == 2) begin
                checks++;
                if ({ram_we_n, ram_addr, ram_wdata} !== {1'b0, 16'h8000, 16'h1234}) begin
                    failures++; $display("FAIL store_pulse got=%b/%h/%h exp=0/8000/1234", ram_we_n, ram_addr, ram_wdata);
                end
            end
            if (k < 4) step();
        end
        checks++;
        if (weLow != 1 || oeHigh != 3) begin
            failures++; $display("FAIL store_strobes we_low=%0d oe_high=%0d exp=1/3", weLow, oeHigh);
        end
        checks++;
        if (sram[0] !== 16'h1234) begin failures++; $display("FAIL store_mem got=%h exp=1234", sram[0]); end
        mem_ctrl = 2'b00;
        step();
        checks++;
        if (mem_valid !== 1'b0) begin failures++; $display("FAIL store_after got=%b exp=0", mem_valid); end
    endtask

    task automatic test_load_fetch();
        mem_ctrl = 2'b01; mem_addr = 16'h8001; if_req = 1; if_addr = 16'h0011;
        step();
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if ({mem_valid, if_valid, stall} !== {(k == 3), (k == 6), (k != 6)}) begin
                failures++; $display("FAIL lf_cyc%0d got=%b exp=%b", k, {mem_valid, if_valid, stall}, {(k == 3), (k == 6), (k != 6)});
            end
            if (k == 3) begin
                checks++;
                if (mem_rdata !== 16'hBEEF) begin failures++; $display("FAIL lf_mem_data got=%h exp=beef", mem_rdata); end
            end
            if (k == 4 || k == 5) begin
                checks++;
                if ({ram_oe_n, ram_addr} !== {1'b0, 16'h0011}) begin
                    failures++; $display("FAIL lf_second_access got=%b/%h exp=0/0011", ram_oe_n, ram_addr);
                end
            end
            if (k < 6) step();
        end
        checks++;
        if ({if_rdata, mem_rdata} !== {16'h7777, 16'hBEEF}) begin
            failures++; $display("FAIL lf_data got=%h/%h exp=7777/beef", if_rdata, mem_rdata);
        end
        mem_ctrl = 2'b00; if_req = 0;
        step();
        checks++;
        if ({mem_valid, if_valid, ram_oe_n} !== 3'b001) begin
            failures++; $display("FAIL lf_after got=%b exp=001", {mem_valid, if_valid, ram_oe_n});
        end
    endtask

    task automatic test_back_to_back();
        int weLow;
        weLow = 0;
        mem_ctrl = 2'b10; mem_addr = 16'h8003; mem_wdata = 16'hCAFE; if_req = 1; if_addr = 16'h0010;
        step();
        for (int k = 1; k <= 7; k++) begin
            if (ram_we_n === 1'b0) weLow++;
            checks++;
            if ({mem_valid, if_valid} !== {(k == 4), (k == 7)}) begin
                failures++; $display("FAIL b2b_cyc%0d got=%b exp=%b", k, {mem_valid, if_valid}, {(k == 4), (k == 7)});
            end
            if (k >= 5) begin
                checks++;
                if (ram_data_oe !== 1'b0) begin failures++; $display("FAIL b2b_rewrite cyc%0d data_oe=%b exp=0", k, ram_data_oe); end
            end
            if (k < 7) step();
        end
        checks++;
        if (weLow != 1 || if_rdata !== 16'h4A08) begin
            failures++; $display("FAIL b2b_result we_low=%0d rdata=%h exp=1/4a08", weLow, if_rdata);
        end
        mem_ctrl = 2'b00; if_req = 0;
        step();
    endtask

    task automatic test_reset_mid_write();
        mem_ctrl = 2'b10; mem_addr = 16'h8002; mem_wdata = 16'h5555;
        step();
        step();
        checks++;
        if (ram_we_n !== 1'b0) begin failures++; $display("FAIL rstw_pulse got=%b exp=0", ram_we_n); end
        rst = 1;
        step();
        checks++;
        if ({ram_we_n, ram_data_oe, ram_oe_n, mem_valid} !== 4'b1010) begin
            failures++; $display("FAIL rstw_pins got=%b exp=1010", {ram_we_n, ram_data_oe, ram_oe_n, mem_valid});
        end
        checks++;
        if ({ram_addr, ram_wdata, mem_rdata, if_rdata} !== 64'h0) begin
            failures++; $display("FAIL rstw_data got=%h exp=0", {ram_addr, ram_wdata, mem_rdata, if_rdata});
        end
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rstw_new_req got=%b exp=1", stall); end
        step();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (mem_valid !== (k == 4)) begin failures++; $display("FAIL rstw_redo cyc%0d got=%b exp=%b", k, mem_valid, (k == 4)); end
            if (k < 4) step();
        end
        mem_ctrl = 2'b00;
        step();
    endtask

    task automatic test_ctrl11();
        mem_ctrl = 2'b11; if_req = 0; mem_addr = 16'h0050;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL c11_stall got=%b exp=0", stall); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({ram_oe_n, ram_we_n, ram_data_oe, mem_valid, if_valid, stall} !== 6'b110000) begin
                failures++; $display("FAIL c11_cyc%0d got=%b exp=110000", k, {ram_oe_n, ram_we_n, ram_data_oe, mem_valid, if_valid, stall});
            end
        end
        mem_ctrl = 2'b00;
        step();
    endtask

    task automatic test_random();
        bit expSt, rdOn, wrOn;
        for (int c = 0; c < 800; c++) begin
            if (!mStallAtEdge) begin
                if_req    = ($urandom_range(0, 9) < 6);
                if_addr   = 16'($urandom_range(64, 255));
                mem_ctrl  = 2'($urandom_range(0, 3));
                mem_addr  = {(($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00), 8'($urandom_range(64, 255))};
                mem_wdata = 16'($urandom);
            end else if (remain > 0 && ownMem) begin
                mem_addr  = 16'($urandom_range(64, 255));
                mem_wdata = 16'($urandom);
            end
            #1;
            expSt = pendMemF() || pendIfF();
            rdOn  = (remain > 0) && !ownWr;
            wrOn  = (remain > 0) && ownWr;
            checks++;
            if ({stall, if_valid, mem_valid} !== {expSt, mIfV, mMemV}) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, {stall, if_valid, mem_valid}, {expSt, mIfV, mMemV});
            end
            checks++;
            if ({ram_oe_n, ram_we_n, ram_data_oe} !== {!rdOn, !(wrOn && remain == 2), wrOn}) begin
                failures++; $display("FAIL rand_pins cyc=%0d got=%b exp=%b", c, {ram_oe_n, ram_we_n, ram_data_oe}, {!rdOn, !(wrOn && remain == 2), wrOn});
            end
            checks++;
            if ({ram_addr, ram_wdata} !== {accAddr, accWdata}) begin
                failures++; $display("FAIL rand_bus cyc=%0d got=%h/%h exp=%h/%h", c, ram_addr, ram_wdata, accAddr, accWdata);
            end
            checks++;
            if ({if_rdata, mem_rdata} !== {mIfD, mMemD}) begin
                failures++; $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", c, if_rdata, mem_rdata, mIfD, mMemD);
            end
            checks++;
            if ((ram_we_n === 1'b0 && ram_oe_n === 1'b0) || (ram_data_oe === 1'b1 && ram_oe_n === 1'b0)) begin
                failures++; $display("FAIL rand_contention cyc=%0d we_n=%b oe_n=%b data_oe=%b", c, ram_we_n, ram_oe_n, ram_data_oe);
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = memInit(i);
        remain = 0; ownMem = 0; ownWr = 0; mIfV = 0; mMemV = 0; mIfSrv = 0; mMemSrv = 0;
        mStallAtEdge = 0; accAddr = 0; accWdata = 0; mIfD = 0; mMemD = 0;
        test_reset();
        test_fetch();
        test_store();
        test_load_fetch();
        test_back_to_back();
        test_reset_mid_write();
        test_ctrl11();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
